alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 29 ++
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: opcode encoding, the tag that tracks each
// in-flight request through the ALU pipeline, and the legal-opcode helper.
package alu_arb_pkg;

    localparam logic [2:0] ALUOP_MAX = 3'd6;
    // Tag ids are sized for the largest supported requester count (8).
    localparam int         ID_MAX_W  = 3;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_NOT = 3'd2,
        ALU_ADD = 3'd3,
        ALU_SUB = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6
    } aluop_e;

    typedef struct packed {
        logic                vld;
        logic                issued;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    function automatic logic aluop_legal(input logic [2:0] op);
        return op <= ALUOP_MAX;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: per-requester request lanes plus a
// shared response bus steered by the one-hot resp_valid strobe.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4
);
    // Handshake: requester i holds req_valid[i] and its operands stable while it
    // wants service; the op is taken in the cycle req_valid[i] && req_ready[i],
    // and valid may drop at any time without a grant. Responses have no ready.
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][2:0]  req_aluop;
    logic [NUM_REQ-1:0][31:0] req_a;
    logic [NUM_REQ-1:0][31:0] req_b;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [31:0]              resp_f;
    logic                     resp_err;

    modport master (
        output req_valid, req_aluop, req_a, req_b,
        input  req_ready, resp_valid, resp_f, resp_err
    );

    modport slave (
        input  req_valid, req_aluop, req_a, req_b,
        output req_ready, resp_valid, resp_f, resp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo NUM_REQ, returned both one-hot and encoded.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    int                 cand;
    logic [NUM_REQ-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        sel       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            sel = NUM_REQ'(1) << cand;
            if (!grant_any && (req & sel) != '0) begin
                grant_any = 1'b1;
                grant     = sel;
                grant_idx = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for a shared pipelined ALU: one grant per cycle, a tag
// pipe matched to the ALU latency to route results, and an alignment checker.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    alu_arbiter_if.slave       bus,
    output logic [2:0]         alu_aluop,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic               alu_valid_i,
    input  logic [31:0]        alu_f,
    input  logic               alu_valid_o,
    output logic               err_mismatch,
    output logic [31:0]        grant_cnt
);

    localparam int SETTLE_W = $clog2(ALU_LAT + 1);

    logic [ID_W-1:0]     rr_ptr_q;
    logic [NUM_REQ-1:0]  arb_req;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                fire;
    tag_t                tag_q [ALU_LAT];
    tag_t                tag_last;
    logic                exp_valid_o;
    logic [SETTLE_W-1:0] settle_q;
    logic                check_en;
    logic [NUM_REQ-1:0]  resp_valid_q;
    logic [31:0]         resp_f_q;
    logic                resp_err_q;
    logic                err_mismatch_q;
    logic [31:0]         grant_cnt_q;

    // Gating the requests (not the grant) keeps req_ready purely a function of
    // current inputs and the pointer.
    assign arb_req = (en && rst_n) ? bus.req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (arb_req),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (fire)
    );

    assign bus.req_ready = grant;

    always_comb begin
        alu_aluop   = '0;
        alu_a       = '0;
        alu_b       = '0;
        alu_valid_i = 1'b0;
        if (fire) begin
            alu_aluop   = bus.req_aluop[grant_idx];
            alu_a       = bus.req_a[grant_idx];
            alu_b       = bus.req_b[grant_idx];
            alu_valid_i = aluop_legal(bus.req_aluop[grant_idx]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_q + {31'b0, fire};
            if (fire) begin
                rr_ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
        end
    end

    // Illegal ops still take a tag slot so their error response keeps ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < ALU_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= {fire, alu_valid_i, ID_MAX_W'(grant_idx)};
            for (int s = 1; s < ALU_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_last    = tag_q[ALU_LAT-1];
    assign exp_valid_o = tag_last.vld && tag_last.issued;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= '0;
            resp_f_q     <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            resp_f_q     <= '0;
            resp_err_q   <= 1'b0;
            if (tag_last.vld) begin
                resp_valid_q <= NUM_REQ'(1) << tag_last.id;
                resp_f_q     <= tag_last.issued ? alu_f : '0;
                resp_err_q   <= !tag_last.issued;
            end
        end
    end

    // The ALU's own valid pipe is not reset, so its output is untrusted until
    // ALU_LAT edges have flushed it after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
        end else if (!check_en) begin
            settle_q <= settle_q + SETTLE_W'(1);
        end
    end

    assign check_en = (settle_q == SETTLE_W'(ALU_LAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_mismatch_q <= 1'b0;
        end else if (check_en && (exp_valid_o != alu_valid_o)) begin
            err_mismatch_q <= 1'b1;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_f     = resp_f_q;
    assign bus.resp_err   = resp_err_q;
    assign err_mismatch   = err_mismatch_q;
    assign grant_cnt      = grant_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a two-stage ALU model and a cycle-stamped
// response scoreboard.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NUM_REQ = 4;
    // Scoreboard entry: {expected cycle[51:36], id[35:33], err[32], f[31:0]}
    localparam int W = 52;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  alu_aluop;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_valid_i;
    logic [31:0] alu_f;
    logic        alu_valid_o;
    logic        err_mismatch;
    logic [31:0] grant_cnt;

    alu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ALU_LAT (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .bus          (bus),
        .alu_aluop    (alu_aluop),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_valid_i  (alu_valid_i),
        .alu_f        (alu_f),
        .alu_valid_o  (alu_valid_o),
        .err_mismatch (err_mismatch),
        .grant_cnt    (grant_cnt)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- ALU model (valid pipe deliberately unreset) ----------------
    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_NOT: return ~a;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SHL: return a << b[4:0];
            ALU_SHR: return a >> b[4:0];
            default: return '0;
        endcase
    endfunction

    logic        s1_v, s2_v;
    logic [2:0]  s1_op;
    logic [31:0] s1_a, s1_b, s2_f;
    logic        inject = 1'b0;
    int          issue_cnt = 0;

    always @(posedge clk) begin
        s1_v  <= alu_valid_i;
        s1_op <= alu_aluop;
        s1_a  <= alu_a;
        s1_b  <= alu_b;
        s2_v  <= s1_v;
        s2_f  <= alu_ref(s1_op, s1_a, s1_b);
        if (alu_valid_i) issue_cnt <= issue_cnt + 1;
    end

    assign alu_valid_o = s2_v | inject;
    assign alu_f       = s2_f;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [NUM_REQ-1:0] mon_onehot;

    task automatic expect_resp(input int id, input logic err, input logic [31:0] f);
        exp_q.push_back({16'(cyc + 3), 3'(id), err, f});
    endtask

    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0][51:36] < cyc[15:0]) begin
            mon_e = exp_q.pop_front();
            chk("resp_missing_cycle", 64'(cyc[15:0]), 64'(mon_e[51:36]));
        end
        if (exp_q.size() != 0 && exp_q[0][51:36] == cyc[15:0]) begin
            mon_e      = exp_q.pop_front();
            mon_onehot = NUM_REQ'(1) << mon_e[35:33];
            chk("resp_valid", 64'(bus.resp_valid), 64'(mon_onehot));
            chk("resp_err", 64'(bus.resp_err), 64'(mon_e[32]));
            chk("resp_f", 64'(bus.resp_f), 64'(mon_e[31:0]));
        end else if (bus.resp_valid !== '0) begin
            chk("resp_spurious", 64'(bus.resp_valid), 64'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_aluop[i] = op;
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_pending", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.req_valid = '0;
        bus.req_aluop = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;

        // Reset state, with requests and enable asserted to prove gating by rst_n
        repeat (3) @(negedge clk);
        en = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        chk("rst_resp_f", 64'(bus.resp_f), 64'(0));
        chk("rst_resp_err", 64'(bus.resp_err), 64'(0));
        chk("rst_err_mismatch", 64'(err_mismatch), 64'(0));
        chk("rst_grant_cnt", 64'(grant_cnt), 64'(0));
        chk("rst_alu_valid_i", 64'(alu_valid_i), 64'(0));
        chk("rst_alu_a", 64'(alu_a), 64'(0));
        chk("rst_alu_aluop", 64'(alu_aluop), 64'(0));
        bus.req_valid = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single requester 0: ADD 5+7
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        bus.req_valid = 4'b0001;
        #1;
        chk("t1_ready", 64'(bus.req_ready), 64'(4'b0001));
        chk("t1_alu_valid_i", 64'(alu_valid_i), 64'(1));
        chk("t1_alu_a", 64'(alu_a), 64'(5));
        chk("t1_alu_b", 64'(alu_b), 64'(7));
        chk("t1_alu_aluop", 64'(alu_aluop), 64'(ALU_ADD));
        expect_resp(0, 1'b0, 32'd12);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("t1_ready_idle", 64'(bus.req_ready), 64'(0));
        chk("t1_grant_cnt", 64'(grant_cnt), 64'(1));
        drain();

        // All four requesters continuously valid from reset: SUB 100-i
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ALU_SUB, 32'd100, 32'(i));
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_rr_order", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            expect_resp(k % 4, 1'b0, 32'(100 - (k % 4)));
            @(negedge clk);
        end
        bus.req_valid = '0;
        drain();
        chk("t2_grant_cnt", 64'(grant_cnt), 64'(8));

        // Illegal opcode from requester 2 between two SHL 1<<4
        set_req(1, ALU_SHL, 32'd1, 32'd4);
        set_req(2, 3'd7, 32'd9, 32'd9);
        set_req(3, ALU_SHL, 32'd1, 32'd4);
        begin
            int issue_base;
            issue_base = issue_cnt;
            bus.req_valid = 4'b1110;
            #1;
            chk("t3_ready_r1", 64'(bus.req_ready), 64'(4'b0010));
            chk("t3_issue_r1", 64'(alu_valid_i), 64'(1));
            expect_resp(1, 1'b0, 32'd16);
            @(negedge clk);
            bus.req_valid = 4'b1100;
            #1;
            chk("t3_ready_r2", 64'(bus.req_ready), 64'(4'b0100));
            chk("t3_issue_r2", 64'(alu_valid_i), 64'(0));
            expect_resp(2, 1'b1, 32'd0);
            @(negedge clk);
            bus.req_valid = 4'b1000;
            #1;
            chk("t3_ready_r3", 64'(bus.req_ready), 64'(4'b1000));
            chk("t3_issue_r3", 64'(alu_valid_i), 64'(1));
            expect_resp(3, 1'b0, 32'd16);
            @(negedge clk);
            bus.req_valid = '0;
            drain();
            chk("t3_alu_pulses", 64'(issue_cnt - issue_base), 64'(2));
            chk("t3_grant_cnt", 64'(grant_cnt), 64'(11));
        end

        // en=0 with two ops in flight
        set_req(0, ALU_ADD, 32'd3, 32'd4);
        set_req(1, ALU_AND, 32'h0000_FF00, 32'h0000_0FF0);
        bus.req_valid = 4'b0011;
        #1;
        chk("t4_ready_r0", 64'(bus.req_ready), 64'(4'b0001));
        expect_resp(0, 1'b0, 32'd7);
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        chk("t4_ready_r1", 64'(bus.req_ready), 64'(4'b0010));
        expect_resp(1, 1'b0, 32'h0000_0F00);
        @(negedge clk);
        en = 1'b0;
        set_req(2, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        set_req(3, ALU_NOT, 32'd0, 32'd0);
        bus.req_valid = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_ready_gated", 64'(bus.req_ready), 64'(0));
            chk("t4_alu_valid_gated", 64'(alu_valid_i), 64'(0));
            @(negedge clk);
        end
        en = 1'b1;
        #1;
        chk("t4_resume_r2", 64'(bus.req_ready), 64'(4'b0100));
        expect_resp(2, 1'b0, 32'h0000_00FF);
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1;
        chk("t4_resume_r3", 64'(bus.req_ready), 64'(4'b1000));
        expect_resp(3, 1'b0, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.req_valid = '0;
        drain();

        // Reset one cycle after two fires; ALU valid forced high while settling
        set_req(0, ALU_AND, 32'h0000_00FF, 32'h0000_000F);
        set_req(1, ALU_SHR, 32'h0000_0080, 32'd4);
        bus.req_valid = 4'b0011;
        #1;
        chk("t5_ready_r0", 64'(bus.req_ready), 64'(4'b0001));
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        chk("t5_ready_r1", 64'(bus.req_ready), 64'(4'b0010));
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b0;
        inject = 1'b1;
        #1;
        chk("t5_resp_in_reset", 64'(bus.resp_valid), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        inject = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_err_masked", 64'(err_mismatch), 64'(0));
        for (int i = 0; i < NUM_REQ; i++) set_req(i, ALU_ADD, 32'd10, 32'(i));
        bus.req_valid = 4'b1111;
        #1;
        chk("t5_ptr_reset", 64'(bus.req_ready), 64'(4'b0001));
        expect_resp(0, 1'b0, 32'd10);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("t5_grant_cnt", 64'(grant_cnt), 64'(1));
        drain();

        // grant_cnt wrap from a preset near 2^32
        force dut.grant_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.grant_cnt_q;
        set_req(1, ALU_ADD, 32'd1, 32'd1);
        bus.req_valid = 4'b0010;
        #1;
        chk("t6_ready_a", 64'(bus.req_ready), 64'(4'b0010));
        expect_resp(1, 1'b0, 32'd2);
        @(negedge clk);
        #1;
        chk("t6_cnt_max", 64'(grant_cnt), 64'(32'hFFFF_FFFF));
        chk("t6_ready_b", 64'(bus.req_ready), 64'(4'b0010));
        expect_resp(1, 1'b0, 32'd2);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("t6_cnt_wrap", 64'(grant_cnt), 64'(0));
        drain();

        // Spurious ALU valid with an empty tag pipe
        chk("t7_err_before", 64'(err_mismatch), 64'(0));
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        chk("t7_err_set", 64'(err_mismatch), 64'(1));
        repeat (3) @(negedge clk);
        chk("t7_err_sticky", 64'(err_mismatch), 64'(1));

        chk("end_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
